// File: rtl/dbg_responder_pkg.sv
// Shared debug package: FSM encodings and default widths used by the responder and the debugger side.
package dbg_responder_pkg;

  localparam int DBG_ADDR_W = 8;
  localparam int DBG_DATA_W = 32;
  localparam int DBG_RF_AW  = 5;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_CAP  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/dbg_responder_if.sv
// Debug inspect bus: shared-memory read port (1-cycle read latency) and combinational register-file read port.
interface dbg_responder_if
  import dbg_responder_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W,
  parameter int RF_AW  = DBG_RF_AW
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [RF_AW-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  modport master (
    output mem_req,
    output mem_raddr,
    output rf_raddr,
    input  mem_rdata,
    input  rf_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_raddr,
    input  rf_raddr,
    output mem_rdata,
    output rf_rdata
  );

endinterface

// File: rtl/dbg_stepgen.sv
// Run/step generator: cpu_en is high for exactly as many cycles as run was sampled high, one cycle late.
// icount counts enabled cycles and wraps at 16 bits; no backpressure.
module dbg_stepgen
  import dbg_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        cpu_en,
  output logic [15:0] icount
);

  run_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= HALT;
      cpu_en <= 1'b0;
      icount <= '0;
    end else begin
      icount <= icount + {15'd0, cpu_en};
      case (state)
        HALT: if (run) begin
          state  <= RUN;
          cpu_en <= 1'b1;
        end
        RUN: if (!run) begin
          state  <= HALT;
          cpu_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dbg_responder.sv
// Debug responder: gates the CPU via dbg_stepgen and reads memory/regfile for the debugger while halted.
// Memory result lands 2 cycles after mem_req; a run request aborts an in-flight read (run always wins).
module dbg_responder
  import dbg_responder_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W,
  parameter int RF_AW  = DBG_RF_AW
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  addr,
  output logic               cpu_en,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic [ADDR_W-1:0]  pc,
  dbg_responder_if.master    bus,
  output logic [DATA_W-1:0]  mem_data,
  output logic [DATA_W-1:0]  reg_data,
  output logic               stale,
  output logic [15:0]        icount
);

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] lat_addr;
  logic              mem_req_q;
  logic              addr_diff;
  logic              unused_pc_bits;

  dbg_stepgen u_stepgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .cpu_en (cpu_en),
    .icount (icount)
  );

  assign addr_diff      = (addr != lat_addr);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_raddr  = lat_addr;
  assign bus.rf_raddr   = addr[RF_AW-1:0];
  assign unused_pc_bits = ^{cpu_pc[DATA_W-1:ADDR_W+2], cpu_pc[1:0]};

  // Reads start only when the CPU is halted now and stays halted next cycle,
  // so mem_req can never overlap cpu_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      lat_addr  <= '0;
      mem_req_q <= 1'b0;
      mem_data  <= '0;
      stale     <= 1'b1;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (!run && !cpu_en && (stale || addr_diff)) begin
            rd_state  <= R_REQ;
            lat_addr  <= addr;
            mem_req_q <= 1'b1;
            stale     <= 1'b1;
          end else begin
            stale <= stale | run | cpu_en | addr_diff;
          end
        end
        R_REQ: begin
          mem_req_q <= 1'b0;
          stale     <= 1'b1;
          rd_state  <= run ? R_IDLE : R_CAP;
        end
        R_CAP: begin
          rd_state <= R_IDLE;
          if (run) begin
            stale <= 1'b1;
          end else begin
            mem_data <= bus.mem_rdata;
            stale    <= addr_diff;
          end
        end
        default: begin
          rd_state  <= R_IDLE;
          mem_req_q <= 1'b0;
          stale     <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_data <= '0;
      pc       <= '0;
    end else begin
      reg_data <= bus.rf_rdata;
      pc       <= cpu_pc[ADDR_W+1:2];
    end
  end

endmodule

// File: tb/tb_dbg_responder.sv
// Bench for dbg_responder: directed steps/reads; a monitor pops queued expected reads on every mem_req
// and checks mem_data/stale two cycles later.
module tb_dbg_responder;

  typedef struct {
    logic [31:0] data;
    logic        stale;
  } cap_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [7:0]  addr;
  logic        cpu_en;
  logic [31:0] cpu_pc;
  logic [7:0]  pc;
  logic [31:0] mem_data;
  logic [31:0] reg_data;
  logic        stale;
  logic [15:0] icount;

  logic [31:0] mem [256];
  logic [7:0]  req_q [$];
  cap_t        cap_q [$];
  int          n_tests = 0;
  int          n_fails = 0;
  int          en_cnt  = 0;
  int          cap_cnt = 0;
  int          en_base;

  dbg_responder_if bus ();

  dbg_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .addr     (addr),
    .cpu_en   (cpu_en),
    .cpu_pc   (cpu_pc),
    .pc       (pc),
    .bus      (bus),
    .mem_data (mem_data),
    .reg_data (reg_data),
    .stale    (stale),
    .icount   (icount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: word r reads as 0xA0000000 | r.
  assign bus.rf_rdata = 32'hA000_0000 | {27'd0, bus.rf_raddr};

  always @(posedge clk) begin
    if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [7:0] a, input logic [31:0] d, input logic s);
    cap_t c;
    c.data  = d;
    c.stale = s;
    req_q.push_back(a);
    cap_q.push_back(c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_en"},   {31'd0, cpu_en},      32'd0);
    check({tag, "_mem_req"},  {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_mem_data"}, mem_data,             32'd0);
    check({tag, "_reg_data"}, reg_data,             32'd0);
    check({tag, "_pc"},       {24'd0, pc},          32'd0);
    check({tag, "_icount"},   {16'd0, icount},      32'd0);
    check({tag, "_stale"},    {31'd0, stale},       32'd1);
  endtask

  // Scoreboard monitor
  initial begin
    cap_t c;
    forever begin
      @(negedge clk);
      if (cap_cnt > 0) begin
        cap_cnt--;
        if (cap_cnt == 0) begin
          if (cap_q.size() == 0) begin
            n_tests++;
            n_fails++;
            $display("FAIL cap_unexpected: got mem_data %h, expected no capture", mem_data);
          end else begin
            c = cap_q.pop_front();
            check("cap_mem_data", mem_data, c.data);
            check("cap_stale", {31'd0, stale}, {31'd0, c.stale});
          end
        end
      end
      if (cpu_en) en_cnt++;
      if (bus.mem_req) begin
        check("mem_req_while_cpu_en", {31'd0, cpu_en}, 32'd0);
        if (req_q.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL req_unexpected: got mem_raddr %h, expected no mem_req", bus.mem_raddr);
        end else begin
          check("mem_raddr", {24'd0, bus.mem_raddr}, {24'd0, req_q.pop_front()});
        end
        cap_cnt = 2;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
    mem[5] = 32'hDEAD_BEEF;
    mem[6] = 32'hCAFE_F00D;

    // Reset, then first read of addr 5
    rst_n  = 1'b0;
    run    = 1'b0;
    addr   = 8'h05;
    cpu_pc = 32'h0000_0014;
    tick(3);
    check_reset_outputs("reset");
    expect_read(8'h05, 32'hDEAD_BEEF, 1'b0);
    rst_n = 1'b1;
    tick(6);
    check("t1_reg_data", reg_data, 32'hA000_0005);
    check("t1_pc", {24'd0, pc}, 32'h0000_0005);
    check("t1_stale", {31'd0, stale}, 32'd0);

    // Single-cycle step, then re-read
    en_base = en_cnt;
    expect_read(8'h05, 32'hDEAD_BEEF, 1'b0);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    check("t2_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t2_stale_in_run", {31'd0, stale}, 32'd1);
    tick(6);
    check("t2_en_cycles", en_cnt - en_base, 32'd1);
    check("t2_icount", {16'd0, icount}, 32'd1);

    // Ten-cycle run from a fresh reset
    rst_n = 1'b0;
    tick(2);
    expect_read(8'h05, 32'hDEAD_BEEF, 1'b0);
    rst_n = 1'b1;
    tick(5);
    cpu_pc  = 32'h0000_03FC;
    en_base = en_cnt;
    expect_read(8'h05, 32'hDEAD_BEEF, 1'b0);
    run = 1'b1;
    tick(10);
    run = 1'b0;
    tick(8);
    check("t3_en_cycles", en_cnt - en_base, 32'd10);
    check("t3_icount", {16'd0, icount}, 32'd10);
    check("t3_pc", {24'd0, pc}, 32'h0000_00FF);

    // addr moves 5 -> 6 while the re-read of 5 is in R_REQ
    expect_read(8'h05, 32'hDEAD_BEEF, 1'b1);
    expect_read(8'h06, 32'hCAFE_F00D, 1'b0);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(2);
    check("t4_in_req", {31'd0, bus.mem_req}, 32'd1);
    addr = 8'h06;
    tick(8);
    check("t4_reg_data", reg_data, 32'hA000_0006);
    check("t4_mem_data", mem_data, 32'hCAFE_F00D);

    // addr change and run rise together: run wins
    expect_read(8'h07, 32'h0000_1007, 1'b0);
    addr = 8'h07;
    run  = 1'b1;
    tick(1);
    run = 1'b0;
    check("t5_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t5_no_req", {31'd0, bus.mem_req}, 32'd0);
    check("t5_stale", {31'd0, stale}, 32'd1);
    tick(7);
    check("t5_mem_data", mem_data, 32'h0000_1007);

    // Reset during R_CAP
    cpu_pc = 32'h0001_0008;
    tick(2);
    check("t6_pc", {24'd0, pc}, 32'h0000_0002);
    expect_read(8'h09, 32'h0000_0000, 1'b1);
    expect_read(8'h09, 32'h0000_1009, 1'b0);
    addr = 8'h09;
    tick(1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midread_reset");
    rst_n = 1'b1;
    tick(7);
    check("t6_mem_data", mem_data, 32'h0000_1009);
    check("t6_stale", {31'd0, stale}, 32'd0);

    // icount wrap: 65535 enabled cycles, then one step
    en_base = en_cnt;
    expect_read(8'h09, 32'h0000_1009, 1'b0);
    run = 1'b1;
    tick(65535);
    run = 1'b0;
    tick(6);
    check("t7_icount_full", {16'd0, icount}, 32'h0000_FFFF);
    check("t7_en_cycles", en_cnt - en_base, 32'd65535);
    expect_read(8'h09, 32'h0000_1009, 1'b0);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(6);
    check("t7_icount_wrap", {16'd0, icount}, 32'h0000_0000);

    tick(4);
    check("req_q_drained", req_q.size(), 32'd0);
    check("cap_q_drained", cap_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/dbg_responder.md
DBG_RESPONDER -- requirements
Module: dbg_responder

Interface
REQ-001 Parameter ADDR_W, default 8: debug/memory address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter RF_AW, default 5: register-file address width.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous reset, active-low.
REQ-006 Port run, input, 1: debugger run level; a one-cycle high pulse is a step request.
REQ-007 Port addr, input, ADDR_W: debugger inspect address.
REQ-008 Port cpu_en, output, 1: CPU clock enable; the CPU advances one instruction per cycle where cpu_en=1.
REQ-009 Port cpu_pc, input, DATA_W: CPU program counter.
REQ-010 Port pc, output, ADDR_W: registered cpu_pc[ADDR_W+1:2], the word index.
REQ-011 Port rf_raddr, output, RF_AW: debug register-file read address, equal to addr[RF_AW-1:0].
REQ-012 Port rf_rdata, input, DATA_W: combinational register-file read data.
REQ-013 Port mem_req, output, 1: debug request for the shared memory read port.
REQ-014 Port mem_raddr, output, ADDR_W: debug memory read address.
REQ-015 Port mem_rdata, input, DATA_W: memory read data, valid exactly one cycle after a mem_req cycle.
REQ-016 Port mem_data / reg_data, output, DATA_W each: registered inspect results.
REQ-017 Port stale, output, 1: high while mem_data does not reflect the current addr.
REQ-018 Port icount, output, 16: count of cycles with cpu_en=1.

Function
REQ-019 Run FSM states: HALT, RUN. HALT->RUN when run=1; RUN->HALT when run=0.
REQ-020 cpu_en SHALL be 1 exactly in cycles where the FSM is in RUN, so a run pulse of N cycles yields exactly N enabled cycles and a 1-cycle pulse yields exactly one.
REQ-021 cpu_en is registered; the first enabled cycle is the cycle after run is first sampled high.
REQ-022 mem_req SHALL be asserted only while the FSM is in HALT and cpu_en=0; the debugger never contends with a running CPU.
REQ-023 Read FSM states: R_IDLE, R_REQ, R_CAP.
- R_IDLE->R_REQ when in HALT and (stale=1 or addr differs from the last latched address).
- R_REQ: mem_req=1, mem_raddr=latched addr, ->R_CAP.
- R_CAP: mem_data<=mem_rdata; stale<=0 unless addr changed during R_REQ; ->R_IDLE.
REQ-024 If the FSM enters RUN during R_REQ or R_CAP, the read is aborted with no mem_data update, stale=1, and the read FSM returns to R_IDLE.
REQ-025 stale SHALL be set in every RUN cycle (memory may change) and on any addr change.
REQ-026 reg_data<=rf_raddr's rf_rdata every cycle (latency 1), independent of the run state.
REQ-027 pc<=cpu_pc slice every cycle.
REQ-028 icount SHALL increment by 1 in each cpu_en=1 cycle, wrapping 0xFFFF->0x0000.
REQ-029 When addr changes and run rises in the same cycle, run wins: no mem_req is issued and stale=1.

Reset
REQ-030 While rst_n=0 at a clock edge: FSM=HALT, read FSM=R_IDLE, cpu_en=0, mem_req=0, mem_data=0, reg_data=0, pc=0, icount=0, stale=1, latched addr=0.
REQ-031 Reset mid-read discards the read; the first post-reset HALT cycle starts a fresh R_REQ (stale=1).

Structure
REQ-032 The FSM state encodings and ADDR_W/DATA_W defaults SHALL reside in the shared debug package, where the debugger-side unit also uses them.
REQ-033 One sub-module, dbg_stepgen (run FSM, cpu_en, icount), SHALL be instantiated; the read FSM stays in dbg_responder.

Verification
REQ-034 Reset, then release with run=0, addr=0x05, mem[5]=0xDEADBEEF -> mem_req high one cycle, mem_data=0xDEADBEEF two cycles later, stale=0.
REQ-035 Single-cycle run pulse -> exactly one cpu_en cycle, icount=1, stale=1, then a re-read of mem_data.
REQ-036 run high 10 cycles -> 10 cpu_en cycles, icount=10, mem_req never high while cpu_en=1.
REQ-037 addr changes 0x05->0x06 during R_REQ -> the 0x05 data is captured with stale=1, then a new read is issued and mem_data=mem[6].
REQ-038 Preload icount=0xFFFF, then one step -> icount=0x0000.
REQ-039 rst_n low during R_CAP -> all outputs at their REQ-030 values; after release, a correct read of the current addr.
